// File: rtl/csa_sub_serial.sv
// csa_sub_serial: multi-cycle carry-skip subtractor, one BLOCK-bit slice per clock
module csa_sub_serial #(
    parameter int WIDTH = 32,
    parameter int BLOCK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);
    localparam int NBLK = WIDTH / BLOCK;
    localparam int CW = $clog2(NBLK + 1);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_nx;
    logic [WIDTH-1:0] a_r, b_r, diff_nx;
    logic [BLOCK-1:0] a_k, nb_k, p, sum;
    logic [CW-1:0] cnt;
    logic c, rc, c_nx, last;
    // current slice: ripple sum, with the carry skipping the slice when every bit propagates
    always_comb begin
        a_k = a_r[cnt*BLOCK +: BLOCK];
        nb_k = ~b_r[cnt*BLOCK +: BLOCK];
        p = a_k ^ nb_k;
        {rc, sum} = {1'b0, a_k} + {1'b0, nb_k} + {{BLOCK{1'b0}}, c};
        c_nx = &p ? c : rc;
        diff_nx = diff;
        diff_nx[cnt*BLOCK +: BLOCK] = sum;
        last = cnt == CW'(NBLK - 1);
    end
    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    end
    // next state and handshake outputs
    always_comb begin
        state_nx = state;
        if (state == IDLE && in_valid) state_nx = BUSY;
        if (state == BUSY && last) state_nx = DONE;
        if (state == DONE && out_ready) state_nx = IDLE;
        in_ready = state == IDLE;
        out_valid = state == DONE;
    end
    // operand capture, per-slice accumulation and flag generation on the last slice
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_r <= '0;
            b_r <= '0;
            c <= 1'b0;
            cnt <= '0;
            diff <= '0;
            bout <= 1'b0;
            ovf <= 1'b0;
            zero <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            a_r <= a;
            b_r <= b;
            c <= ~bin;
            cnt <= '0;
        end else if (state == BUSY) begin
            diff <= diff_nx;
            c <= c_nx;
            cnt <= last ? cnt : cnt + 1'b1;
            if (last) begin
                bout <= ~c_nx;
                ovf <= (a_r[WIDTH-1] != b_r[WIDTH-1]) && (diff_nx[WIDTH-1] != a_r[WIDTH-1]);
                zero <= ~|diff_nx;
            end
        end
    end
endmodule

// File: tb/tb_csa_sub_serial.sv
// tb_csa_sub_serial: directed and random checks of the serial carry-skip subtractor
module tb_csa_sub_serial;
    logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0, bin = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic in_ready, out_valid, bout, ovf, zero;
    logic [31:0] diff;
    int total = 0, bad = 0;

    csa_sub_serial dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .bout(bout), .ovf(ovf), .zero(zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a, b;
        logic bin;
        logic [31:0] d;
        logic bo, ov, z;
    } vec_t;

    vec_t v[5] = '{
        '{32'h00000005, 32'h00000003, 1'b0, 32'h00000002, 1'b0, 1'b0, 1'b0},
        '{32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0},
        '{32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0},
        '{32'h12345678, 32'h12345678, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1},
        '{32'h12345678, 32'h12345678, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0}
    };

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [31:0] ta, input logic [31:0] tb, input logic tbin,
                         input int gap, output logic [31:0] d, output logic bo,
                         output logic ov, output logic z, output int lat);
        int n = 0;
        while (!in_ready && n < 20) begin
            step;
            n++;
        end
        a = ta;
        b = tb;
        bin = tbin;
        in_valid = 1'b1;
        step;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            step;
            lat++;
        end
        d = diff;
        bo = bout;
        ov = ovf;
        z = zero;
        repeat (gap) step;
        out_ready = 1'b1;
        step;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] d, ra, rb;
        logic bo, ov, z, rbin;
        logic [32:0] m;
        longint sr;
        int lat, pulses;

        repeat (2) step;
        chk("rst_diff", diff, 0);
        chk("rst_flags", {bout, ovf, zero, out_valid}, 0);
        chk("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        step;

        for (int i = 0; i < 5; i++) begin
            do_op(v[i].a, v[i].b, v[i].bin, i, d, bo, ov, z, lat);
            chk($sformatf("v%0d_lat", i), lat, 4);
            chk($sformatf("v%0d_diff", i), d, v[i].d);
            chk($sformatf("v%0d_bout", i), bo, v[i].bo);
            chk($sformatf("v%0d_ovf", i), ov, v[i].ov);
            chk($sformatf("v%0d_zero", i), z, v[i].z);
            chk($sformatf("v%0d_post", i), {out_valid, in_ready}, 2'b01);
        end

        a = 32'd7;
        b = 32'd2;
        bin = 1'b0;
        in_valid = 1'b1;
        step;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            step;
            lat++;
        end
        chk("bp_lat", lat, 4);
        for (int i = 0; i < 5; i++) begin
            a = $urandom;
            b = $urandom;
            in_valid = i[0];
            step;
            chk("bp_diff", diff, 32'd5);
            chk("bp_hs", {out_valid, in_ready, bout, ovf, zero}, 5'b10000);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step;
        out_ready = 1'b0;
        chk("bp_release", {out_valid, in_ready}, 2'b01);
        step;
        chk("bp_no_accept", {out_valid, in_ready}, 2'b01);

        a = 32'hFFFF0010;
        b = 32'h00000001;
        bin = 1'b1;
        in_valid = 1'b1;
        step;
        in_valid = 1'b0;
        step;
        rst_n = 1'b0;
        step;
        chk("mid_rst_diff", diff, 0);
        chk("mid_rst_hs", {out_valid, in_ready, bout, ovf, zero}, 5'b01000);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            step;
            if (out_valid) pulses++;
        end
        chk("mid_rst_no_valid", pulses, 0);

        for (int i = 0; i < 2000; i++) begin
            ra = $urandom;
            rb = $urandom;
            rbin = 1'($urandom_range(0, 1));
            case (i % 4)
                1: ra = rb;
                2: ra = rb + 32'(rbin);
                default: ;
            endcase
            do_op(ra, rb, rbin, $urandom_range(0, 3), d, bo, ov, z, lat);
            m = {1'b0, ra} - {1'b0, rb} - 33'(rbin);
            sr = longint'($signed(ra)) - longint'($signed(rb)) - longint'(rbin);
            chk("rnd_lat", lat, 4);
            chk("rnd_bout_diff", {bo, d}, m);
            chk("rnd_ovf", ov, (sr > 64'sd2147483647) || (sr < -64'sd2147483648));
            chk("rnd_zero", z, m[31:0] == 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
